// File: rtl/chaser_mode_ctrl_if.sv
// Button-to-configuration bundle between the chaser mode controller and its
// surroundings. The slave side is the controller; the master side drives the
// raw buttons and consumes the chaser configuration.
interface chaser_mode_ctrl_if;
  logic       btn_next_raw;
  logic       btn_adj_raw;
  logic [2:0] speed_sel;
  logic       tail_en;
  logic       direction;
  logic       led_invert;
  logic [1:0] field_sel;
  logic       cfg_changed;

  modport master (
    output btn_next_raw,
    output btn_adj_raw,
    input  speed_sel,
    input  tail_en,
    input  direction,
    input  led_invert,
    input  field_sel,
    input  cfg_changed
  );

  modport slave (
    input  btn_next_raw,
    input  btn_adj_raw,
    output speed_sel,
    output tail_en,
    output direction,
    output led_invert,
    output field_sel,
    output cfg_changed
  );
endinterface

// File: rtl/chaser_mode_ctrl.sv
// Two-button mode controller for the 7-segment chaser/fader.
// "next" walks the field selector (SPEED -> TAIL -> DIR -> INV), "adjust"
// changes the selected field. Both buttons are synchronised and debounced.
// Optional build macro CHASER_MODE_CTRL_AUTO_REPEAT_EN adds auto-repeat of a
// held adjust button every 2^REPEAT_WIDTH cycles.
module chaser_mode_ctrl #(
  parameter int unsigned DEBOUNCE_WIDTH = 12,
  parameter int unsigned REPEAT_WIDTH   = 16,
  parameter logic [2:0]  SPEED_RESET    = 3'd4
) (
  input logic               clk,
  input logic               reset,
  chaser_mode_ctrl_if.slave bus_io
);

  localparam int unsigned BtnNext = 0;
  localparam int unsigned BtnAdj  = 1;

  typedef enum logic [1:0] {
    StSpeed = 2'd0,
    StTail  = 2'd1,
    StDir   = 2'd2,
    StInv   = 2'd3
  } field_e;

  logic [1:0]                raw;
  logic [1:0]                s1_q, s2_q;
  logic [1:0]                stable_q, stable_d;
  logic [1:0]                prev_q;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q [2];
  logic [DEBOUNCE_WIDTH-1:0] cnt_d [2];

  logic next_evt;
  logic adj_press;
  logic adj_evt;
  logic adj_apply;

  field_e     field_q;
  logic [2:0] speed_q;
  logic       tail_q;
  logic       dir_q;
  logic       inv_q;
  logic       apply_q;
  logic       cfg_changed_q;

  assign raw = {bus_io.btn_adj_raw, bus_io.btn_next_raw};

  // Debounce next-state: count while the synchronised level disagrees with
  // the accepted level; accept it once the counter has saturated.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == {DEBOUNCE_WIDTH{1'b1}}) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Synchronisers, debounce state and previous-level registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q     <= '0;
      s2_q     <= '0;
      stable_q <= '0;
      prev_q   <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      prev_q   <= stable_q;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign next_evt  = stable_q[BtnNext] & ~prev_q[BtnNext];
  assign adj_press = stable_q[BtnAdj] & ~prev_q[BtnAdj];

`ifdef CHASER_MODE_CTRL_AUTO_REPEAT_EN
  logic [REPEAT_WIDTH-1:0] rpt_q;
  logic                    rpt_hold;
  logic                    rpt_evt;

  // Counting starts the cycle after the press event so repeats land exactly
  // 2^REPEAT_WIDTH cycles apart, including the first one.
  assign rpt_hold = stable_q[BtnAdj] & prev_q[BtnAdj];
  assign rpt_evt  = rpt_hold & (rpt_q == {REPEAT_WIDTH{1'b1}});

  // Hold counter for auto-repeat; wraps naturally from all-ones to zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q <= '0;
    end else if (!rpt_hold || next_evt) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_q + 1'b1;
    end
  end

  assign adj_evt = adj_press | rpt_evt;
`else
  logic unused_repeat_width;
  assign unused_repeat_width = ^REPEAT_WIDTH;
  assign adj_evt = adj_press;
`endif

  // Next has priority; a coincident adjust is dropped, not queued.
  assign adj_apply = adj_evt & ~next_evt;

  // Field FSM and configuration registers; cfg_changed trails the change by one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_q       <= StSpeed;
      speed_q       <= SPEED_RESET;
      tail_q        <= 1'b1;
      dir_q         <= 1'b1;
      inv_q         <= 1'b0;
      apply_q       <= 1'b0;
      cfg_changed_q <= 1'b0;
    end else begin
      apply_q       <= adj_apply;
      cfg_changed_q <= apply_q;
      if (next_evt) begin
        unique case (field_q)
          StSpeed: field_q <= StTail;
          StTail:  field_q <= StDir;
          StDir:   field_q <= StInv;
          StInv:   field_q <= StSpeed;
        endcase
      end else if (adj_evt) begin
        unique case (field_q)
          StSpeed: speed_q <= speed_q + 3'd1;
          StTail:  tail_q  <= ~tail_q;
          StDir:   dir_q   <= ~dir_q;
          StInv:   inv_q   <= ~inv_q;
        endcase
      end
    end
  end

  assign bus_io.speed_sel   = speed_q;
  assign bus_io.tail_en     = tail_q;
  assign bus_io.direction   = dir_q;
  assign bus_io.led_invert  = inv_q;
  assign bus_io.field_sel   = field_q;
  assign bus_io.cfg_changed = cfg_changed_q;

endmodule
